// File: rtl/inst_cache_param_if.sv
// ----------------------------------------------------------------------------
// inst_cache_param_if
// Purpose : groups the IF-stage fetch signals and the SRAM-like instruction
//           bus signals of the instruction cache into one bundle.
// Signals :
//   cpu_req, pc, flush                     - fetch request from IF
//   IF_instruction, pc_wait_stop_choke     - fetched word and IF stall
//   inst_sram_req/wr/size/wstrb/addr/wdata - bus request side (cache drives)
//   inst_sram_addr_ok/data_ok/rdata        - bus response side (memory drives)
// Modports:
//   slave  - the cache itself (serves IF, issues bus reads)
//   master - the surrounding environment (IF stage plus bus memory)
// ----------------------------------------------------------------------------
interface inst_cache_param_if;
    logic        cpu_req;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] IF_instruction;
    logic        pc_wait_stop_choke;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport slave (
        input  cpu_req, pc, flush,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output IF_instruction, pc_wait_stop_choke,
        output inst_sram_req, inst_sram_wr, inst_sram_size,
        output inst_sram_wstrb, inst_sram_addr, inst_sram_wdata
    );

    modport master (
        output cpu_req, pc, flush,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  IF_instruction, pc_wait_stop_choke,
        input  inst_sram_req, inst_sram_wr, inst_sram_size,
        input  inst_sram_wstrb, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/inst_cache_param.sv
// ----------------------------------------------------------------------------
// inst_cache_param
// Purpose : direct-mapped instruction cache between IF and the SRAM-like
//           instruction bus. Hits are answered combinationally; a miss stalls
//           IF and refills the whole line with single-word reads, beat 0 first.
// Parameters:
//   INDEX_BITS  - 2^INDEX_BITS lines
//   OFFSET_BITS - 2^OFFSET_BITS words per line (0..4)
// Ports:
//   clk    - clock, all state changes on the rising edge
//   resetn - synchronous active-low reset
//   cif    - inst_cache_param_if.slave (IF fetch + instruction bus)
//   perf_hit_cnt / perf_miss_cnt - only present with ICACHE_PERF_CNT_EN
// Optional feature:
//   ICACHE_PERF_CNT_EN - adds 32-bit wrapping hit and miss counters
// ----------------------------------------------------------------------------
module inst_cache_param #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2
) (
    input  logic clk,
    input  logic resetn,
    inst_cache_param_if.slave cif
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);

    localparam int TAG_BITS     = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES        = 1 << INDEX_BITS;
    localparam int WORDS        = 1 << OFFSET_BITS;
    localparam int CNT_BITS     = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
    localparam int DATA_BITS    = INDEX_BITS + OFFSET_BITS;
    localparam int DATA_ENTRIES = LINES * WORDS;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic [31:0]           r_data [DATA_ENTRIES];
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [LINES-1:0]      r_valid;

    logic [TAG_BITS-1:0]   r_missTag;
    logic [INDEX_BITS-1:0] r_missIndex;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  r_flushPend;

    logic [29:0]           w_wordAddr;
    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_index;
    logic [DATA_BITS-1:0]  w_dataIdx;
    logic [DATA_BITS-1:0]  w_fillIdx;
    logic [31:0]           w_beatAddr;
    logic                  w_lastBeat;
    logic                  w_hit;
    logic                  w_startFill;
    logic                  w_beatDone;
    logic                  w_fillDone;
    logic                  w_flushAll;

    // The low DATA_BITS of the word address are exactly {index, offset},
    // which is the flat position of the word in the data array.
    assign w_wordAddr = cif.pc[31:2];
    assign w_tag      = w_wordAddr[29 -: TAG_BITS];
    assign w_index    = w_wordAddr[OFFSET_BITS +: INDEX_BITS];
    assign w_dataIdx  = w_wordAddr[DATA_BITS-1:0];

    // With single-word lines there is no offset field, so the beat counter
    // must not appear in the fill index or the bus address.
    if (OFFSET_BITS > 0) begin : g_multiWord
        assign w_fillIdx  = {r_missIndex, r_cnt};
        assign w_beatAddr = {r_missTag, r_missIndex, r_cnt, 2'b00};
    end else begin : g_singleWord
        assign w_fillIdx  = r_missIndex;
        assign w_beatAddr = {r_missTag, r_missIndex, 2'b00};
    end

    assign w_lastBeat  = (r_cnt == CNT_BITS'(WORDS - 1));
    assign w_hit       = cif.cpu_req && r_valid[w_index] &&
                         (r_tag[w_index] == w_tag) && (r_state == IDLE);
    assign w_startFill = (r_state == IDLE) && cif.cpu_req && !w_hit;
    assign w_beatDone  = (r_state == WAIT) && cif.inst_sram_data_ok;
    assign w_fillDone  = w_beatDone && w_lastBeat;
    // A flush arriving on the final beat is folded in so it is not lost
    // when the pending flag is dropped on the return to IDLE.
    assign w_flushAll  = r_flushPend || cif.flush;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_startFill) w_nextState = REQ;
            REQ:  if (cif.inst_sram_addr_ok) w_nextState = WAIT;
            WAIT: if (cif.inst_sram_data_ok) w_nextState = w_lastBeat ? IDLE : REQ;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        cif.inst_sram_req      = (r_state == REQ);
        cif.inst_sram_addr     = w_beatAddr;
        cif.inst_sram_wr       = 1'b0;
        cif.inst_sram_size     = 2'b10;
        cif.inst_sram_wstrb    = 4'b0000;
        cif.inst_sram_wdata    = 32'h0;
        cif.IF_instruction     = r_data[w_dataIdx];
        cif.pc_wait_stop_choke = cif.cpu_req && !w_hit;
    end

    // Miss bookkeeping: the refill target is frozen at the miss so later pc
    // changes cannot redirect it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_missTag   <= '0;
            r_missIndex <= '0;
            r_cnt       <= '0;
            r_flushPend <= 1'b0;
        end else begin
            if (w_startFill) begin
                r_missTag   <= w_tag;
                r_missIndex <= w_index;
                r_cnt       <= '0;
            end else if (w_beatDone) begin
                r_cnt <= r_cnt + CNT_BITS'(1);
            end
            if (w_fillDone) begin
                r_flushPend <= 1'b0;
            end else if ((r_state != IDLE) && cif.flush) begin
                r_flushPend <= 1'b1;
            end
        end
    end

    // The refilled line is invalid from its first beat until its last, so a
    // half-written line can never hit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= '0;
        end else if ((r_state == IDLE) && cif.flush) begin
            r_valid <= '0;
        end else if (w_fillDone) begin
            if (w_flushAll) begin
                r_valid <= '0;
            end else begin
                r_valid[r_missIndex] <= 1'b1;
            end
        end else if (w_beatDone && (r_cnt == '0)) begin
            r_valid[r_missIndex] <= 1'b0;
        end
    end

    // Data and tag storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (resetn && w_beatDone) begin
            r_data[w_fillIdx] <= cif.inst_sram_rdata;
        end
        if (resetn && w_fillDone) begin
            r_tag[r_missIndex] <= r_missTag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_perfHit;
    logic [31:0] r_perfMiss;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_perfHit  <= '0;
            r_perfMiss <= '0;
        end else begin
            if (w_hit)       r_perfHit  <= r_perfHit + 32'd1;
            if (w_startFill) r_perfMiss <= r_perfMiss + 32'd1;
        end
    end

    assign perf_hit_cnt  = r_perfHit;
    assign perf_miss_cnt = r_perfMiss;
`endif

endmodule
